fifo_sync: RTL and testbench

//  Single-clock FIFO. Parametrised successor of the dual-clock FIFO, for buffers that live in one clock domain
//  (stream pipelines, DMA staging), so no Gray-code pointer synchronisers.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_sync_ram.sv | 38 +++
 rtl/fifo_sync.sv | 158 +++++++++++++++
 tb/tb_fifo_sync.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and sizing helpers for the single- and dual-clock FIFOs.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Number of words addressed by a log2-sized memory.
  function automatic int unsigned depth_of(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int unsigned clog2_of(input int unsigned value);
    int unsigned bits;
    bits = 1;
    while ((32'd1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned MEM_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [MEM_SIZE-1:0]   waddr,
  input  logic [WIDTH_DATA-1:0] wdata,
  input  logic                  re,
  input  logic [MEM_SIZE-1:0]   raddr,
  output logic [WIDTH_DATA-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(MEM_SIZE);

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; only reset clears it, so it holds across flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill level,
// almost thresholds, synchronous flush and sticky overflow/underflow.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned MEM_SIZE   = 4,
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned AFULL_LVL  = depth_of(MEM_SIZE) - 1,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  we,
  input  logic [WIDTH_DATA-1:0] wdata,
  input  logic                  re,
  output logic [WIDTH_DATA-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [MEM_SIZE:0]     level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = depth_of(MEM_SIZE);
  localparam int unsigned PTR_W = MEM_SIZE + 1;
  localparam fifo_mode_e  MODE  = FWFT ? FIFO_FWFT : FIFO_STD;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] level_n;
  out_state_e       out_state;
  out_state_e       out_state_n;
  logic             ctl_en;
  logic             ram_has_word;
  logic             wr_acc;
  logic             rd_acc;
  logic             ram_re;
  logic             empty_n;

  // Contents of the RAM alone (excludes the FWFT output stage).
  assign ram_has_word = (wr_ptr != rd_ptr);
  // Flush and reset both block any transfer in their cycle.
  assign ctl_en = !rst && !flush;

  // Accept decisions, RAM read issue, output-stage next state and next level.
  always_comb begin
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    ram_re      = 1'b0;
    out_state_n = out_state;
    level_n     = level;

    wr_acc = ctl_en && we && !full;
    rd_acc = ctl_en && re && !empty;

    if (MODE == FIFO_FWFT) begin
      case (out_state)
        OUT_EMPTY: begin
          if (ctl_en && ram_has_word) begin
            ram_re      = 1'b1;
            out_state_n = OUT_VALID;
          end
        end
        OUT_VALID: begin
          if (rd_acc) begin
            if (ram_has_word) begin
              ram_re = 1'b1;
            end else begin
              out_state_n = OUT_EMPTY;
            end
          end
        end
        default: out_state_n = OUT_EMPTY;
      endcase
    end else begin
      ram_re = rd_acc;
    end

    if (wr_acc && !rd_acc) begin
      level_n = level + PTR_W'(1);
    end else if (rd_acc && !wr_acc) begin
      level_n = level - PTR_W'(1);
    end

    if (flush) begin
      out_state_n = OUT_EMPTY;
      level_n     = '0;
    end

    if (MODE == FIFO_FWFT) begin
      empty_n = (out_state_n == OUT_EMPTY);
    end else begin
      empty_n = (level_n == '0);
    end
  end

  // FWFT output-stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_EMPTY;
    end else begin
      out_state <= out_state_n;
    end
  end

  // Pointers, level and status flags, all registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(wr_acc);
        rd_ptr <= rd_ptr + PTR_W'(ram_re);
      end
      level        <= level_n;
      full         <= (level_n == PTR_W'(DEPTH));
      empty        <= empty_n;
      almost_full  <= (level_n >= PTR_W'(AFULL_LVL));
      almost_empty <= (level_n <= PTR_W'(AEMPTY_LVL));
      if (ctl_en && we && full) begin
        overflow <= 1'b1;
      end
      if (ctl_en && re && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_sync_ram #(
    .WIDTH_DATA (WIDTH_DATA),
    .MEM_SIZE   (MEM_SIZE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[MEM_SIZE-1:0]),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (rd_ptr[MEM_SIZE-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: one standard-mode and one FWFT instance.
module tb_fifo_sync;

  localparam int unsigned W  = 8;
  localparam int unsigned MS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          s_flush, s_we, s_re;
  logic [W-1:0]  s_wdata, s_rdata;
  logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [MS:0]   s_level;

  logic          f_flush, f_we, f_re;
  logic [W-1:0]  f_wdata, f_rdata;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [MS:0]   f_level;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] vec2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp3 [6] = '{8'h66, 8'h77, 8'hA0, 8'hA1, 8'hA2, 8'hA3};

  fifo_sync #(
    .WIDTH_DATA (W), .MEM_SIZE (MS), .FWFT (1'b0), .AFULL_LVL (3), .AEMPTY_LVL (1)
  ) u_dut_std (
    .clk (clk), .rst (rst), .flush (s_flush), .we (s_we), .wdata (s_wdata), .re (s_re),
    .rdata (s_rdata), .full (s_full), .empty (s_empty), .almost_full (s_afull),
    .almost_empty (s_aempty), .level (s_level), .overflow (s_ovf), .underflow (s_udf)
  );

  fifo_sync #(
    .WIDTH_DATA (W), .MEM_SIZE (MS), .FWFT (1'b1), .AFULL_LVL (3), .AEMPTY_LVL (1)
  ) u_dut_fwft (
    .clk (clk), .rst (rst), .flush (f_flush), .we (f_we), .wdata (f_wdata), .re (f_re),
    .rdata (f_rdata), .full (f_full), .empty (f_empty), .almost_full (f_afull),
    .almost_empty (f_aempty), .level (f_level), .overflow (f_ovf), .underflow (f_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    s_flush = 1'b0; s_we = 1'b0; s_re = 1'b0; s_wdata = '0;
    f_flush = 1'b0; f_we = 1'b0; f_re = 1'b0; f_wdata = '0;

    // 1: reset state
    tick(); tick();
    check("rst_empty",  32'(s_empty),  32'd1);
    check("rst_full",   32'(s_full),   32'd0);
    check("rst_level",  32'(s_level),  32'd0);
    check("rst_aempty", 32'(s_aempty), 32'd1);
    check("rst_afull",  32'(s_afull),  32'd0);
    check("rst_rdata",  32'(s_rdata),  32'h00);
    check("rst_ovf",    32'(s_ovf),    32'd0);
    check("rst_udf",    32'(s_udf),    32'd0);
    check("rst_f_empty", 32'(f_empty), 32'd1);
    rst = 1'b0;

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1; s_wdata = vec2[i];
      tick();
      check("fill_level", 32'(s_level), 32'(i + 1));
      check("fill_afull", 32'(s_afull), (i >= 2) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(s_empty), 32'd0);
    end
    check("fill_full", 32'(s_full), 32'd1);
    s_wdata = 8'h55;
    tick();
    s_we = 1'b0;
    check("ovf_level", 32'(s_level), 32'd4);
    check("ovf_flag",  32'(s_ovf),   32'd1);
    check("ovf_full",  32'(s_full),  32'd1);
    for (int i = 0; i < 4; i++) begin
      s_re = 1'b1;
      tick();
      check("drain_rdata", 32'(s_rdata), 32'(vec2[i]));
      check("drain_level", 32'(s_level), 32'(3 - i));
    end
    s_re = 1'b0;
    check("drain_empty",  32'(s_empty),  32'd1);
    check("drain_full",   32'(s_full),   32'd0);
    check("drain_aempty", 32'(s_aempty), 32'd1);
    check("drain_udf",    32'(s_udf),    32'd0);

    // 3: simultaneous read/write across pointer wrap
    s_we = 1'b1; s_wdata = 8'h66; tick();
    s_wdata = 8'h77; tick();
    check("rw_pre_level", 32'(s_level), 32'd2);
    for (int i = 0; i < 6; i++) begin
      s_we = 1'b1; s_re = 1'b1; s_wdata = 8'hA0 + 8'(i);
      tick();
      check("rw_level", 32'(s_level), 32'd2);
      check("rw_rdata", 32'(s_rdata), 32'(exp3[i]));
    end
    s_we = 1'b0; s_re = 1'b0;

    // 5: flush beats simultaneous we/re; sticky flags and rdata kept
    s_we = 1'b1; s_wdata = 8'hC0; tick();
    check("pre_flush_level", 32'(s_level), 32'd3);
    s_flush = 1'b1; s_we = 1'b1; s_re = 1'b1; s_wdata = 8'hEE;
    tick();
    s_flush = 1'b0; s_we = 1'b0; s_re = 1'b0;
    check("flush_level",  32'(s_level),  32'd0);
    check("flush_empty",  32'(s_empty),  32'd1);
    check("flush_full",   32'(s_full),   32'd0);
    check("flush_afull",  32'(s_afull),  32'd0);
    check("flush_aempty", 32'(s_aempty), 32'd1);
    check("flush_ovf",    32'(s_ovf),    32'd1);
    check("flush_udf",    32'(s_udf),    32'd0);
    check("flush_rdata",  32'(s_rdata),  32'hA3);
    tick();
    check("flush_idle_level", 32'(s_level), 32'd0);

    // 6: underflow, then reset mid-fill
    s_re = 1'b1; tick(); s_re = 1'b0;
    check("udf_flag",  32'(s_udf),   32'd1);
    check("udf_level", 32'(s_level), 32'd0);
    check("udf_rdata", 32'(s_rdata), 32'hA3);
    s_we = 1'b1; s_wdata = 8'h12; tick();
    s_wdata = 8'h34; tick();
    s_we = 1'b0;
    check("mid_level", 32'(s_level), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_level", 32'(s_level), 32'd0);
    check("mrst_udf",   32'(s_udf),   32'd0);
    check("mrst_ovf",   32'(s_ovf),   32'd0);
    check("mrst_empty", 32'(s_empty), 32'd1);
    check("mrst_rdata", 32'(s_rdata), 32'h00);
    s_we = 1'b1; s_wdata = 8'h5A; tick(); s_we = 1'b0;
    s_re = 1'b1; tick(); s_re = 1'b0;
    check("mrst_rdata_new", 32'(s_rdata), 32'h5A);

    // 4: FWFT write-to-empty latency and consume
    f_we = 1'b1; f_wdata = 8'hA5; tick(); f_we = 1'b0;
    check("fwft_c1_empty", 32'(f_empty), 32'd1);
    check("fwft_c1_level", 32'(f_level), 32'd1);
    tick();
    check("fwft_c2_empty", 32'(f_empty), 32'd0);
    check("fwft_c2_rdata", 32'(f_rdata), 32'hA5);
    tick();
    check("fwft_c3_rdata", 32'(f_rdata), 32'hA5);
    f_re = 1'b1; tick(); f_re = 1'b0;
    check("fwft_c4_empty", 32'(f_empty), 32'd1);
    check("fwft_c4_level", 32'(f_level), 32'd0);

    // FWFT refill from RAM on consume
    f_we = 1'b1; f_wdata = 8'hB1; tick();
    f_wdata = 8'hB2; tick(); f_we = 1'b0;
    tick();
    check("fwft_b1_rdata", 32'(f_rdata), 32'hB1);
    check("fwft_b1_level", 32'(f_level), 32'd2);
    f_re = 1'b1; tick();
    check("fwft_b2_rdata", 32'(f_rdata), 32'hB2);
    check("fwft_b2_empty", 32'(f_empty), 32'd0);
    check("fwft_b2_level", 32'(f_level), 32'd1);
    tick();
    check("fwft_end_empty", 32'(f_empty), 32'd1);
    check("fwft_end_level", 32'(f_level), 32'd0);
    check("fwft_no_udf",    32'(f_udf),   32'd0);
    tick(); f_re = 1'b0;
    check("fwft_udf", 32'(f_udf), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
